// File: rtl/encoder_8to3.sv
// rtl/encoder_8to3.sv - 8-to-3 priority encoder with registered index, valid and optional multi-bit error flag.
// Optional feature macro: ENCODER_ONEHOT_CHECK_EN (adds err output).
module encoder_8to3 #(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    output logic [2:0] out,
`ifdef ENCODER_ONEHOT_CHECK_EN
    output logic       valid,
    output logic       err
`else
    output logic       valid
`endif
);

    logic [2:0] w_idx;
    logic       w_any;
    logic [2:0] r_out;
    logic       r_valid;

    // Scan order picks the winner: the last set bit seen overwrites earlier ones.
    always_comb begin
        w_idx = 3'd0;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < 8; i++) begin
                if (in[i]) w_idx = i[2:0];
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (in[i]) w_idx = i[2:0];
            end
        end
    end

    assign w_any = |in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= 3'd0;
            r_valid <= 1'b0;
        end else begin
            r_out   <= w_any ? w_idx : 3'd0;
            r_valid <= w_any;
        end
    end

    assign out   = r_out;
    assign valid = r_valid;

`ifdef ENCODER_ONEHOT_CHECK_EN
    logic w_multi;
    logic r_err;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi = |(in & (in - 8'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_multi;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_encoder_8to3.sv
// tb/tb_encoder_8to3.sv - directed self-checking bench for encoder_8to3 (both priority settings).
module tb_encoder_8to3;

    logic       clk;
    logic       rst;
    logic [7:0] in_v;
    logic [2:0] out_hi, out_lo;
    logic       valid_hi, valid_lo;
`ifdef ENCODER_ONEHOT_CHECK_EN
    logic       err_hi, err_lo;
`endif

    int checks;
    int failures;

    encoder_8to3 #(.PRIORITY_HIGH(1'b1)) dut_hi (
        .clk   (clk),
        .rst   (rst),
        .in    (in_v),
        .out   (out_hi),
`ifdef ENCODER_ONEHOT_CHECK_EN
        .valid (valid_hi),
        .err   (err_hi)
`else
        .valid (valid_hi)
`endif
    );

    encoder_8to3 #(.PRIORITY_HIGH(1'b0)) dut_lo (
        .clk   (clk),
        .rst   (rst),
        .in    (in_v),
        .out   (out_lo),
`ifdef ENCODER_ONEHOT_CHECK_EN
        .valid (valid_lo),
        .err   (err_lo)
`else
        .valid (valid_lo)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a value at the falling edge, then sample 1ns after the capturing rising edge.
    task automatic apply(input logic [7:0] v);
        @(negedge clk);
        in_v = v;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_both(input string tag, input logic [2:0] e_hi, input logic [2:0] e_lo,
                               input logic e_valid);
        chk({tag, "_out_hi"}, {5'd0, out_hi}, {5'd0, e_hi});
        chk({tag, "_out_lo"}, {5'd0, out_lo}, {5'd0, e_lo});
        chk({tag, "_valid_hi"}, {7'd0, valid_hi}, {7'd0, e_valid});
        chk({tag, "_valid_lo"}, {7'd0, valid_lo}, {7'd0, e_valid});
    endtask

    initial begin
        logic [7:0] walk [8];
        logic [2:0] idx;
        checks   = 0;
        failures = 0;
        walk     = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        // Reset held with all inputs active: outputs must stay cleared.
        rst  = 1'b1;
        in_v = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        expect_both("reset", 3'd0, 3'd0, 1'b0);
`ifdef ENCODER_ONEHOT_CHECK_EN
        chk("reset_err_hi", {7'd0, err_hi}, 8'd0);
        chk("reset_err_lo", {7'd0, err_lo}, 8'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            apply(walk[k]);
            idx = k[2:0];
            expect_both($sformatf("walk%0d", k), idx, idx, 1'b1);
        end

        apply(8'h00);
        expect_both("zero", 3'd0, 3'd0, 1'b0);

        apply(8'b1000_0001);
        expect_both("prio81", 3'd7, 3'd0, 1'b1);
        apply(8'b0011_0000);
        expect_both("prio30", 3'd5, 3'd4, 1'b1);

`ifdef ENCODER_ONEHOT_CHECK_EN
        apply(8'b0000_0110);
        expect_both("err06", 3'd2, 3'd1, 1'b1);
        chk("err06_err", {6'd0, err_hi, err_lo}, 8'd3);
        apply(8'b0000_0100);
        chk("err04_err", {6'd0, err_hi, err_lo}, 8'd0);
        apply(8'h00);
        chk("err00_err", {6'd0, err_hi, err_lo}, 8'd0);
`endif

        // Random one-hot stream: each output reflects the input of the previous edge.
        for (int k = 0; k < 20; k++) begin
            idx = 3'($urandom_range(7));
            apply(8'd1 << idx);
            expect_both($sformatf("rand%0d", k), idx, idx, 1'b1);
        end

        // Mid-cycle asynchronous reset clears outputs before the next edge.
        apply(8'h80);
        expect_both("pre_async", 3'd7, 3'd7, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        expect_both("async_rst", 3'd0, 3'd0, 1'b0);
        @(negedge clk);
        in_v = 8'h02;
        rst  = 1'b0;
        @(posedge clk);
        #1;
        expect_both("post_rst", 3'd1, 3'd1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encoder_8to3.md
Name: encoder_8to3

Overview:
- 8-to-3 binary encoder with registered outputs: maps an 8-bit one-hot input to its 3-bit bit index.
- Sits on control/decode paths where one-hot request or select vectors are converted to a binary index for muxing or addressing.
- Defined priority when more than one bit is set; a valid flag distinguishes "index 0" from "no input active".

Parameters:
- PRIORITY_HIGH, 1, 1 = highest set bit index wins; 0 = lowest set bit index wins (applies only when more than one input bit is set).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in  input  8  one-hot input vector; bit i active means code i
- out  output  3  encoded index of the active input bit, registered
- valid  output  1  registered; 1 when at least one input bit was set
- err  output  1  registered; multiple-bit error flag (present only with ENCODER_ONEHOT_CHECK_EN)

Behaviour:
- One clock; reset is asynchronous and active-high (rst); all state clocked on rising clk.
- Reset: while rst is high, out=3'b000 and valid=0 (and err=0 when present), immediately and regardless of clk. First capture happens on the first rising clk after rst deasserts.
- Latency: exactly 1 cycle. The value of in sampled at rising edge N appears on out/valid after edge N and holds until the next edge.
- Encoding for a one-hot input: in=8'b0000_0001 gives out=0; 8'b0000_0010 gives 1; 8'b0000_0100 gives 2; 8'b0000_1000 gives 3; 8'b0001_0000 gives 4; 8'b0010_0000 gives 5; 8'b0100_0000 gives 6; 8'b1000_0000 gives 7. valid=1 in all these cases.
- in=8'b0000_0000 gives out=3'b000 and valid=0. out is forced to 0, not held at its previous value.
- Multiple bits set:
  - PRIORITY_HIGH=1: out = index of the most significant set bit (8'b1000_0001 gives 7).
  - PRIORITY_HIGH=0: out = index of the least significant set bit (8'b1000_0001 gives 0).
  - valid=1 in either case.
- Encoding logic is purely combinational ahead of the output register. The block has no other state and no handshake.
- If rst asserts mid-stream, outputs clear at once. Input values present during reset are discarded.
- X/Z on in is not required to be handled; the bench drives only known values.

Optional Feature:
- Macro ENCODER_ONEHOT_CHECK_EN.
- Defined:
  - err port exists.
  - err is registered with the same 1-cycle latency as out.
  - err=1 when more than one bit of in was set at the sampling edge; otherwise 0.
  - Reset value of err is 0.
  - out and valid behave exactly as without the macro (priority rule still applies).
- Undefined: no err port and no popcount/check logic. Multiple-bit inputs resolve silently by PRIORITY_HIGH.

Test Plan:
- Reset: hold rst=1 with in=8'hFF and toggle clk -> out=0, valid=0 (err=0). Assert rst asynchronously between edges -> outputs clear before the next edge.
- Walking one: drive in=01,02,04,08,10,20,40,80 (hex), one per cycle -> out=0..7 respectively, valid=1, each one cycle after its input.
- Zero input: in=8'h00 after in=8'h80 -> next cycle out=0, valid=0.
- Priority: PRIORITY_HIGH=1, in=8'b1000_0001 -> out=7; in=8'b0011_0000 -> out=5. With PRIORITY_HIGH=0, the same inputs give out=0 and out=4. valid=1 throughout.
- Error flag (ENCODER_ONEHOT_CHECK_EN): in=8'b0000_0110 -> err=1; in=8'b0000_0100 -> err=0; in=8'h00 -> err=0, each one cycle later.
- Latency: change in on every cycle with a random one-hot value -> out always equals the index of the previous cycle's input.
